rr_arbiter_8: RTL and testbench

- 8-requester round-robin arbiter that shares one resource.
- Grant is one-hot. It is produced by registering a 3-bit owner index and driving it through a 3-to-8 one-hot decoder.
- Sits between eight request sources and the shared resource's select/enable lines.
- Limits how long one owner can hold the resource so that no requester starves.

---
 rtl/rr_arbiter_8_pkg.sv | 29 ++
 rtl/rr_arbiter_8_dec.sv | 15 +
 rtl/rr_arbiter_8.sv | 89 ++++++++
 tb/tb_rr_arbiter_8.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// Shared types, constants and the round-robin search used by the 8-way arbiter.
package rr_arbiter_8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set bit of req_vec scanning upward from last+1 with wrap-around.
  // Callers only use the result when req_vec is non-zero.
  function automatic logic [IDX_W-1:0] rr_next(input logic [N_REQ-1:0] req_vec,
                                                input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_next = last;
    found   = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last + IDX_W'(i);
      if (!found && req_vec[idx]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_8_dec.sv
// 3-to-8 one-hot decoder with enable; output is all zero when disabled.
module onehot_dec3to8
  import rr_arbiter_8_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with a bounded hold time per owner.
//   state | meaning
//   IDLE  | no grant active, waiting for any request
//   GRANT | gnt_idx owns the resource; release, preempt or hold each cycle
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             gnt_new
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state;
  logic [7:0]       hold_cnt;
  logic [IDX_W-1:0] last_idx;

  logic [N_REQ-1:0] owner_mask;
  logic [N_REQ-1:0] others;
  logic [N_REQ-1:0] search_req;
  logic [IDX_W-1:0] winner;

  // gnt comes straight from registered index/valid, so it stays glitch-free.
  onehot_dec3to8 u_dec (
    .idx    (gnt_idx),
    .en     (gnt_valid),
    .onehot (gnt)
  );

  always_comb begin
    owner_mask = '0;
    owner_mask[gnt_idx] = 1'b1;
    others     = req & ~owner_mask;
    search_req = (state == GRANT) ? others : req;
    winner     = rr_next(search_req, last_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      gnt_new   <= 1'b0;
      hold_cnt  <= '0;
      last_idx  <= IDX_W'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          gnt_new <= 1'b0;
          if (|req) begin
            gnt_idx   <= winner;
            last_idx  <= winner;
            gnt_valid <= 1'b1;
            gnt_new   <= 1'b1;
            hold_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!req[gnt_idx] || (hold_cnt == HOLD_LAST && |others)) begin
            if (|others) begin
              gnt_idx   <= winner;
              last_idx  <= winner;
              gnt_new   <= 1'b1;
              hold_cnt  <= '0;
            end else begin
              gnt_valid <= 1'b0;
              gnt_new   <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            gnt_new <= 1'b0;
            // Saturating: a late competitor preempts on its first pending cycle.
            if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed testbench for rr_arbiter_8 with hand-computed expectations.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       gnt_new;

  int total;
  int bad;

  rr_arbiter_8 #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .gnt_new   (gnt_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || gnt_new !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle c=%0d: gnt=%h valid=%b idx=%0d new=%b, required 00/0/0/0",
                 c, gnt, gnt_valid, gnt_idx, gnt_new);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h01;
    step();
    total++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_new !== 1'b1 || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: gnt=%h idx=%0d new=%b valid=%b, required 01/0/1/1",
               gnt, gnt_idx, gnt_new, gnt_valid);
    end
    step();
    total++;
    if (gnt !== 8'h01 || gnt_new !== 1'b0) begin
      bad++;
      $display("FAIL single_hold: gnt=%h new=%b, required 01/0", gnt, gnt_new);
    end
    req = 8'h00;
    step();
    total++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0 || gnt_new !== 1'b0) begin
      bad++;
      $display("FAIL single_release: gnt=%h valid=%b idx=%0d new=%b, required 00/0/0/0",
               gnt, gnt_valid, gnt_idx, gnt_new);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] one;
    logic [7:0] exp_gnt;
    int         exp;
    one = 8'h01;
    do_reset();
    req = 8'hFF;
    step();
    for (int k = 0; k <= 8; k++) begin
      exp     = k % 8;
      exp_gnt = one << exp;
      total++;
      if (gnt !== exp_gnt || gnt_idx !== 3'(exp) || gnt_new !== 1'b1 || gnt_valid !== 1'b1) begin
        bad++;
        $display("FAIL b2b_handoff k=%0d: gnt=%h idx=%0d new=%b valid=%b, required %h/%0d/1/1",
                 k, gnt, gnt_idx, gnt_new, gnt_valid, exp_gnt, exp);
      end
      for (int j = 0; j < 2; j++) begin
        step();
        total++;
        if (gnt !== exp_gnt || gnt_new !== 1'b0) begin
          bad++;
          $display("FAIL b2b_hold k=%0d j=%0d: gnt=%h new=%b, required %h/0",
                   k, j, gnt, gnt_new, exp_gnt);
        end
      end
      if (k < 8) begin
        req = 8'hFF & ~exp_gnt;
        step();
        req = 8'hFF;
      end
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_preempt();
    logic [7:0] exp_gnt;
    logic       exp_new;
    do_reset();
    req = 8'h05;
    step();
    for (int c = 0; c < 64; c++) begin
      exp_gnt = (((c / 16) % 2) == 1) ? 8'h04 : 8'h01;
      exp_new = ((c % 16) == 0);
      total++;
      if (gnt !== exp_gnt || gnt_new !== exp_new || gnt_valid !== 1'b1) begin
        bad++;
        $display("FAIL preempt c=%0d: gnt=%h new=%b valid=%b, required %h/%b/1",
                 c, gnt, gnt_new, gnt_valid, exp_gnt, exp_new);
      end
      step();
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_saturate();
    do_reset();
    req = 8'h08;
    step();
    for (int c = 0; c < 40; c++) begin
      total++;
      if (gnt !== 8'h08 || gnt_idx !== 3'd3 || gnt_new !== (c == 0)) begin
        bad++;
        $display("FAIL sat_hold c=%0d: gnt=%h idx=%0d new=%b, required 08/3/%b",
                 c, gnt, gnt_idx, gnt_new, (c == 0));
      end
      step();
    end
    req = 8'h48;
    step();
    total++;
    if (gnt !== 8'h40 || gnt_idx !== 3'd6 || gnt_new !== 1'b1) begin
      bad++;
      $display("FAIL sat_preempt: gnt=%h idx=%0d new=%b, required 40/6/1", gnt, gnt_idx, gnt_new);
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h10;
    step();
    step();
    total++;
    if (gnt !== 8'h10) begin
      bad++;
      $display("FAIL midrst_pre: gnt=%h, required 10", gnt);
    end
    rst = 1'b1;
    step();
    total++;
    if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || gnt_new !== 1'b0) begin
      bad++;
      $display("FAIL midrst_drop: gnt=%h idx=%0d valid=%b new=%b, required 00/0/0/0",
               gnt, gnt_idx, gnt_valid, gnt_new);
    end
    rst = 1'b0;
    req = 8'h90;
    step();
    total++;
    if (gnt !== 8'h10 || gnt_idx !== 3'd4 || gnt_new !== 1'b1 || gnt_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_first: gnt=%h idx=%0d new=%b valid=%b, required 10/4/1/1",
               gnt, gnt_idx, gnt_new, gnt_valid);
    end
    req = 8'h00;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_preempt();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
